// File: rtl/pwm_pkg.sv
// Shared key indices, step codes and repeat-FSM states for the multi-channel PWM controller.
package pwm_pkg;
    localparam int KEY_INC_C = 0;
    localparam int KEY_DEC_C = 1;
    localparam int KEY_INC_F = 2;
    localparam int KEY_HALF  = 3;
    localparam int NKEYS     = 4;

    typedef enum logic [2:0] {
        STEP_NONE,
        STEP_INC_C,
        STEP_DEC_C,
        STEP_INC_F,
        STEP_HALF
    } step_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RPT
    } rpt_state_t;
endpackage

// File: rtl/multi_pwm_controller_if.sv
// Key/channel-select inputs and PWM/readback outputs of the multi-channel PWM controller.
interface multi_pwm_controller_if #(
    parameter int CH    = 4,
    parameter int WIDTH = 8
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [3:0]       keys;
    logic [SW-1:0]    ch_sel;
    logic [CH-1:0]    pwm_out;
    logic [WIDTH-1:0] duty_out;
    logic             period_tick;

    modport master (output keys, output ch_sel, input pwm_out, input duty_out, input period_tick);
    modport slave  (input keys, input ch_sel, output pwm_out, output duty_out, output period_tick);
endinterface

// File: rtl/pwm_key_repeat.sv
// Key priority arbitration plus press/auto-repeat FSM; emits a one-cycle step pulse with its code.
module pwm_key_repeat
    import pwm_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [NKEYS-1:0] i_keys,
    output logic             o_step_valid,
    output step_t            o_step
);
    localparam int MAXCNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW     = $clog2(MAXCNT + 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    rpt_state_t    r_state;
    step_t         r_key;
    step_t         r_step;
    logic          r_step_valid;
    logic [CW-1:0] r_cnt;
    step_t         w_win;

    always_comb begin
        w_win = STEP_NONE;
        if (i_keys[KEY_INC_C])      w_win = STEP_INC_C;
        else if (i_keys[KEY_DEC_C]) w_win = STEP_DEC_C;
        else if (i_keys[KEY_INC_F]) w_win = STEP_INC_F;
        else if (i_keys[KEY_HALF])  w_win = STEP_HALF;
    end

    // The press cycle itself counts as the first held cycle of DELAY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= IDLE;
            r_key        <= STEP_NONE;
            r_step       <= STEP_NONE;
            r_step_valid <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_step_valid <= 1'b0;
            if (w_win == STEP_NONE) begin
                r_state <= IDLE;
                r_key   <= STEP_NONE;
                r_cnt   <= '0;
            end else if (r_state == IDLE || w_win != r_key) begin
                r_state      <= DELAY;
                r_key        <= w_win;
                r_step       <= w_win;
                r_step_valid <= 1'b1;
                r_cnt        <= CW'(1);
            end else if ((r_state == DELAY && r_cnt == DELAY_LAST) ||
                         (r_state == RPT && r_cnt == RATE_LAST)) begin
                r_state      <= RPT;
                r_step       <= r_key;
                r_step_valid <= 1'b1;
                r_cnt        <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_step_valid = r_step_valid;
    assign o_step       = r_step;
endmodule

// File: rtl/multi_pwm_controller.sv
// Multi-channel PWM with key-stepped duty registers, double-buffered into the comparators at period end.
module multi_pwm_controller
    import pwm_pkg::*;
#(
    parameter int CH           = 4,
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 195,
    parameter int STEP_COARSE  = 10,
    parameter int STEP_FINE    = 1,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input logic                   CLK,
    input logic                   RSTn,
    multi_pwm_controller_if.slave bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] HALF     = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-1:0] r_active [CH];
    logic [WIDTH-1:0] r_shadow [CH];
    logic             r_pwm    [CH];
    logic             w_seg_en;
    logic             w_tick;
    logic             w_step_valid;
    step_t            w_step;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_new;
    logic [W1-1:0]    w_sum;
    logic [W1-1:0]    w_diff;

    pwm_key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_repeat (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .i_keys       (bus.keys),
        .o_step_valid (w_step_valid),
        .o_step       (w_step)
    );

    assign w_seg_en = (r_pre == PRE_LAST);
    assign w_tick   = w_seg_en && (r_phase == MAX);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pre   <= '0;
            r_phase <= '0;
        end else if (w_seg_en) begin
            r_pre   <= '0;
            r_phase <= r_phase + WIDTH'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Selected channel's active duty; an out-of-range select matches nothing and reads 0.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < CH; i++) begin
            if (bus.ch_sel == SW'(i)) w_cur = r_active[i];
        end
    end

    // One spare bit catches both overflow past MAX and borrow below 0.
    always_comb begin
        w_sum  = {1'b0, w_cur} + ((w_step == STEP_INC_F) ? W1'(STEP_FINE) : W1'(STEP_COARSE));
        w_diff = {1'b0, w_cur} - W1'(STEP_COARSE);
        case (w_step)
            STEP_INC_C, STEP_INC_F: w_new = w_sum[WIDTH] ? MAX : w_sum[WIDTH-1:0];
            STEP_DEC_C:             w_new = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
            STEP_HALF:              w_new = HALF;
            default:                w_new = w_cur;
        endcase
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_active[gi] <= '0;
                r_shadow[gi] <= '0;
                r_pwm[gi]    <= 1'b0;
            end else begin
                if (w_step_valid && bus.ch_sel == SW'(gi)) r_active[gi] <= w_new;
                if (w_tick) r_shadow[gi] <= r_active[gi];
                r_pwm[gi] <= (r_shadow[gi] == MAX) || (r_phase < r_shadow[gi]);
            end
        end
        assign bus.pwm_out[gi] = r_pwm[gi];
    end

    assign bus.duty_out    = w_cur;
    assign bus.period_tick = w_tick;
endmodule

// File: tb/tb_multi_pwm_controller.sv
// Directed bench for multi_pwm_controller on a small build (3 channels, 4-cycle segments, 1024-cycle period).
module tb_multi_pwm_controller;
    localparam int CH     = 3;
    localparam int WIDTH  = 8;
    localparam int PERIOD = 1024;

    logic CLK = 1'b0;
    logic RSTn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hi [CH];

    multi_pwm_controller_if #(.CH(CH), .WIDTH(WIDTH)) bus ();

    multi_pwm_controller #(
        .CH           (CH),
        .WIDTH        (WIDTH),
        .PRESCALE     (4),
        .STEP_COARSE  (10),
        .STEP_FINE    (1),
        .REPEAT_DELAY (100),
        .REPEAT_RATE  (20)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic count_window(input int n);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) if (bus.pwm_out[c]) hi[c]++;
            cycles(1);
        end
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (bus.period_tick !== 1'b1 && k < 2 * PERIOD) begin
            cycles(1);
            k++;
        end
        if (bus.period_tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    task automatic pulse(input logic [3:0] k, input int n);
        bus.keys = k;
        cycles(n);
        bus.keys = '0;
        cycles(3);
    endtask

    initial begin
        int first_t, last_t, n_t, pwm_seen, c;
        RSTn = 1'b0;
        bus.keys = '0;
        bus.ch_sel = '0;
        cycles(3);
        check("rst_pwm", bus.pwm_out, 0);
        check("rst_duty", bus.duty_out, 0);
        check("rst_tick", bus.period_tick, 0);

        // Idle for two periods: outputs low, ticks exactly one period apart.
        RSTn = 1'b1;
        first_t = -1; last_t = -1; n_t = 0; pwm_seen = 0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            if (bus.period_tick) begin
                n_t++;
                if (first_t < 0) first_t = k;
                last_t = k;
            end
            if (bus.pwm_out != '0) pwm_seen++;
            cycles(1);
        end
        check("idle_ticks", n_t, 2);
        check("idle_first_tick", first_t, PERIOD - 1);
        check("idle_tick_gap", last_t - first_t, PERIOD);
        check("idle_pwm_high", pwm_seen, 0);

        // Three-cycle press gives exactly one coarse step, visible two cycles after the press.
        bus.ch_sel = 2'd1;
        bus.keys = 4'b0001;
        cycles(1);
        check("lat_n1", bus.duty_out, 0);
        cycles(1);
        check("lat_n2", bus.duty_out, 10);
        cycles(1);
        bus.keys = '0;
        cycles(5);
        check("one_step", bus.duty_out, 10);
        wait_tick();
        cycles(2);
        count_window(PERIOD);
        check("ch1_high", hi[1], 40);
        check("ch0_high", hi[0], 0);
        check("ch2_high", hi[2], 0);

        // Out-of-range select: step dropped, readback 0.
        bus.ch_sel = 2'd3;
        pulse(4'b0001, 1);
        check("oor_duty", bus.duty_out, 0);
        bus.ch_sel = 2'd1; #1;
        check("oor_ch1", bus.duty_out, 10);
        bus.ch_sel = 2'd0; #1;
        check("oor_ch0", bus.duty_out, 0);
        bus.ch_sel = 2'd2; #1;
        check("oor_ch2", bus.duty_out, 0);

        // Auto-repeat: 400-cycle hold gives 1 + 1 + 15 steps.
        bus.ch_sel = 2'd0; #1;
        bus.keys = 4'b0001;
        cycles(400);
        bus.keys = '0;
        cycles(3);
        check("rpt_400", bus.duty_out, 170);
        bus.keys = 4'b0001;
        cycles(2);
        check("rpt_press", bus.duty_out, 180);
        cycles(298);
        bus.keys = '0;
        cycles(3);
        check("rpt_sat", bus.duty_out, 255);
        wait_tick();
        cycles(2);
        count_window(PERIOD);
        check("ch0_const1", hi[0], PERIOD);

        // Fine up to 5, then coarse down floors at 0.
        bus.ch_sel = 2'd2; #1;
        repeat (5) pulse(4'b0100, 1);
        check("fine_x5", bus.duty_out, 5);
        pulse(4'b0010, 1);
        check("dec_to_0", bus.duty_out, 0);
        pulse(4'b0010, 1);
        check("dec_floor", bus.duty_out, 0);

        // Priority, and a winner change restarting the delay.
        bus.keys = 4'b1001;
        cycles(2);
        check("prio_coarse", bus.duty_out, 10);
        bus.keys = 4'b1000;
        cycles(2);
        check("half", bus.duty_out, 127);
        bus.keys = '0;
        cycles(3);
        bus.keys = 4'b0101;
        cycles(2);
        check("prio_c_over_f", bus.duty_out, 137);
        cycles(48);
        bus.keys = 4'b0100;
        cycles(2);
        check("switch_fine", bus.duty_out, 138);
        cycles(98);
        check("restart_wait", bus.duty_out, 138);
        cycles(1);
        check("restart_step", bus.duty_out, 139);
        bus.keys = '0;
        cycles(3);

        // Step landing on the tick cycle: old duty for one more period.
        bus.ch_sel = 2'd1; #1;
        wait_tick();
        cycles(PERIOD - 1);
        bus.keys = 4'b0001;
        cycles(1);
        check("tick_step_cycle", bus.period_tick, 1);
        bus.keys = '0;
        cycles(2);
        count_window(PERIOD);
        check("old_duty_high", hi[1], 40);
        count_window(PERIOD);
        check("new_duty_high", hi[1], 80);
        check("duty_20", bus.duty_out, 20);

        // Asynchronous reset in the middle of a repeat.
        bus.ch_sel = 2'd0; #1;
        bus.keys = 4'b0001;
        cycles(150);
        check("pre_rst_pwm0", bus.pwm_out[0], 1);
        RSTn = 1'b0;
        #2;
        check("arst_pwm", bus.pwm_out, 0);
        check("arst_duty", bus.duty_out, 0);
        check("arst_tick", bus.period_tick, 0);
        bus.keys = '0;
        cycles(3);
        RSTn = 1'b1;
        c = 0;
        while (bus.period_tick !== 1'b1 && c < 2 * PERIOD) begin
            cycles(1);
            c++;
        end
        check("restart_first_tick", c, PERIOD - 1);
        check("post_rst_duty", bus.duty_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
